stq_commit_drain: RTL and testbench
===================================

// Module: stq_commit_drain
// PURPOSE
//  Parametrised store-commit tracker and drain engine for the STQ. Each cycle it
//  counts stores retiring across COMMIT_WIDTH lanes and emits their STQ indices.
//  It owns the STQ commit pointer and a count of committed-but-unwritten stores.
//  Through a valid/ack handshake it drains those stores one per cycle to the
//  D-cache write port, and reports each freed STQ entry back to the LSQ.
// PARAMETERS
//  COMMIT_WIDTH  4   retire lanes; any value >= 1
//  STQ_DEPTH     32  STQ entries; power of two, >= COMMIT_WIDTH
//  STQ_LOG       5   $clog2(STQ_DEPTH)
//  CNT_W         3   $clog2(COMMIT_WIDTH+1)
// PORTS
//  clk               in   1                  core clock, rising edge
//  reset             in   1                  async, active-low; all state cleared while low
//  commitStore_i     in   COMMIT_WIDTH       bit k=1: retiring lane k is a store (any pattern)
//  drainEn_i         in   1                  permit new drain requests (0 = fence/hold)
//  drainAck_i        in   1                  D-cache accepts current drain request
//  commitStCount_o   out  CNT_W              popcount(commitStore_i)
//  commitStValid_o   out  COMMIT_WIDTH       thermometer: low commitStCount_o bits set
//  commitStIndex_o   out  [COMMIT_WIDTH]xSTQ_LOG  slot j = commitPtr+j when valid, else 0
//  stqCommitPtr_o    out  STQ_LOG            next STQ entry to commit
//  drainReq_o        out  1                  drain request valid
//  drainIndex_o      out  STQ_LOG            STQ entry being drained
//  pendingCnt_o      out  STQ_LOG+1          committed, not yet drained
//  stqFree_o         out  1                  one-cycle pulse: entry freed
//  stqFreeIndex_o    out  STQ_LOG            index of freed entry
//  commitOverflow_o  out  1                  sticky error flag
// BEHAVIOUR
//  Reset: commitPtr=0, drainPtr=0, pending=0, FSM=IDLE. All registered outputs are 0.
//   Reset is asynchronous: drainReq_o drops immediately, even in mid-handshake.
//  Commit path (same cycle, combinational from commitStore_i and commitPtr):
//   - count = popcount(commitStore_i); stores are always packed into slots 0..count-1.
//   - index[j] = (commitPtr+j) mod STQ_DEPTH. Natural STQ_LOG-bit wrap.
//   - Next edge: commitPtr += count (mod STQ_DEPTH).
//  Pending: next = pending + count - (drainReq_o & drainAck_i).
//   - If next > STQ_DEPTH: set commitOverflow_o (sticky until reset), saturate
//     pending at STQ_DEPTH. commitPtr still advances.
//  Drain FSM (IDLE, REQ); drainReq_o = (state==REQ); drainIndex_o = drainPtr.
//   - IDLE->REQ when pending!=0 && drainEn_i (registered: req appears the next cycle).
//     A commit seen with pending==0 is first requestable 2 cycles later.
//   - In REQ, req and index are held stable until ack; drainEn_i=0 does not retract
//     an outstanding request.
//   - REQ & ack: drainPtr++ (wraps). Stay in REQ if pending_next!=0 && drainEn_i
//     (back-to-back, 1 store/cycle); otherwise go to IDLE.
//   - drainAck_i outside REQ is ignored.
//   - stqFree_o / stqFreeIndex_o are registered: they pulse 1 cycle after the ack,
//     carrying the drained index.
//  Simultaneous commit + ack: both are applied in the same edge; net pending change
//   is count-1.
//  Invariant: drainPtr + pending == commitPtr (mod STQ_DEPTH), except after overflow.
// TESTING
//  1 reset low mid-REQ -> drainReq_o, pendingCnt_o, stqCommitPtr_o are all 0 at
//    once; state stays 0 after release.
//  2 ptr=0, commitStore_i=4'b1010 -> count=2, valid=0011, index={0,1,0,0};
//    next cycle ptr=2, pending=2.
//  3 ptr=30, 4'b1111 -> indices {30,31,0,1}; ptr->2; drainIndex_o wraps 31->0
//    during drain.
//  4 3 pending, drainEn=1, ack low 5 cycles -> req high, index 0 stable; then ack
//    every cycle -> indices 0,1,2 back-to-back, stqFree pulses 0,1,2, pending 0, IDLE.
//  5 In REQ with pending=1, commit 4'b0011 + ack same cycle -> pending=2, FSM stays
//    REQ, drainIndex_o advances.
//  6 ack low, commit 32 stores, then 4'b0001 -> commitOverflow_o=1 (sticky),
//    pendingCnt_o=32; drainEn=0 in IDLE -> no req.

Source files
------------

// File: rtl/stq_commit_drain.sv
// Store-queue commit tracker: packs retiring stores into STQ slots, counts the
// committed-but-unwritten backlog and drains it one entry per ack to the D-cache.
module stq_commit_drain #(
  parameter int COMMIT_WIDTH = 4,
  parameter int STQ_DEPTH    = 32,
  parameter int STQ_LOG      = $clog2(STQ_DEPTH),
  parameter int CNT_W        = $clog2(COMMIT_WIDTH + 1)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [COMMIT_WIDTH-1:0]               commitStore_i,
  input  logic                                  drainEn_i,
  input  logic                                  drainAck_i,
  output logic [CNT_W-1:0]                      commitStCount_o,
  output logic [COMMIT_WIDTH-1:0]               commitStValid_o,
  output logic [COMMIT_WIDTH-1:0][STQ_LOG-1:0]  commitStIndex_o,
  output logic [STQ_LOG-1:0]                    stqCommitPtr_o,
  output logic                                  drainReq_o,
  output logic [STQ_LOG-1:0]                    drainIndex_o,
  output logic [STQ_LOG:0]                      pendingCnt_o,
  output logic                                  stqFree_o,
  output logic [STQ_LOG-1:0]                    stqFreeIndex_o,
  output logic                                  commitOverflow_o
);

  // Two spare bits so pending + count can exceed STQ_DEPTH without wrapping.
  localparam int PW = STQ_LOG + 2;
  localparam logic [PW-1:0] DEPTH_W = PW'(STQ_DEPTH);

  typedef enum logic {IDLE, REQ} state_t;

  state_t             state;
  logic [STQ_LOG-1:0] commit_ptr;
  logic [STQ_LOG-1:0] drain_ptr;
  logic [STQ_LOG:0]   pending;
  logic [CNT_W-1:0]   count;
  logic               fire;
  logic [PW-1:0]      pend_sum;
  logic               overflow;
  logic [STQ_LOG:0]   pend_next;

  // NOTE: every always_comb output gets a default before any conditional
  // update, otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    count = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      count = count + CNT_W'(commitStore_i[k]);
    end
  end

  // Stores are packed into the low slots regardless of which lanes retired them.
  always_comb begin
    commitStValid_o = '0;
    commitStIndex_o = '0;
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      commitStValid_o[j] = (CNT_W'(j) < count);
      if (commitStValid_o[j]) begin
        commitStIndex_o[j] = commit_ptr + STQ_LOG'(j);
      end
    end
  end

  assign fire      = (state == REQ) && drainAck_i;
  assign pend_sum  = PW'(pending) + PW'(count) - PW'(fire);
  assign overflow  = (pend_sum > DEPTH_W);
  assign pend_next = overflow ? DEPTH_W[STQ_LOG:0] : pend_sum[STQ_LOG:0];

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      commit_ptr       <= '0;
      drain_ptr        <= '0;
      pending          <= '0;
      stqFree_o        <= 1'b0;
      stqFreeIndex_o   <= '0;
      commitOverflow_o <= 1'b0;
    end else begin
      commit_ptr     <= commit_ptr + STQ_LOG'(count);
      pending        <= pend_next;
      stqFree_o      <= fire;
      stqFreeIndex_o <= fire ? drain_ptr : '0;
      if (overflow) begin
        commitOverflow_o <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (pending != '0 && drainEn_i) begin
            state <= REQ;
          end
        end
        REQ: begin
          // An outstanding request is never retracted; only an ack ends it.
          if (drainAck_i) begin
            drain_ptr <= drain_ptr + 1'b1;
            state     <= (pend_next != '0 && drainEn_i) ? REQ : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stqCommitPtr_o  = commit_ptr;
  assign drainReq_o      = (state == REQ);
  assign drainIndex_o    = drain_ptr;
  assign pendingCnt_o    = pending;
  assign commitStCount_o = count;

endmodule

// File: tb/tb_stq_commit_drain.sv
// Bench for stq_commit_drain: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an integer-level model.
module tb_stq_commit_drain;

  localparam int CW    = 4;
  localparam int DEPTH = 32;
  localparam int LOG   = 5;
  localparam int CNTW  = 3;

  logic                    clk;
  logic                    rst_n;
  logic [CW-1:0]           commit_store;
  logic                    drain_en;
  logic                    drain_ack;
  logic [CNTW-1:0]         st_count;
  logic [CW-1:0]           st_valid;
  logic [CW-1:0][LOG-1:0]  st_index;
  logic [LOG-1:0]          commit_ptr;
  logic                    drain_req;
  logic [LOG-1:0]          drain_index;
  logic [LOG:0]            pending_cnt;
  logic                    stq_free;
  logic [LOG-1:0]          stq_free_index;
  logic                    overflow;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  stq_commit_drain #(
    .COMMIT_WIDTH(CW), .STQ_DEPTH(DEPTH), .STQ_LOG(LOG), .CNT_W(CNTW)
  ) u_dut (
    .clk              (clk),
    .reset            (rst_n),
    .commitStore_i    (commit_store),
    .drainEn_i        (drain_en),
    .drainAck_i       (drain_ack),
    .commitStCount_o  (st_count),
    .commitStValid_o  (st_valid),
    .commitStIndex_o  (st_index),
    .stqCommitPtr_o   (commit_ptr),
    .drainReq_o       (drain_req),
    .drainIndex_o     (drain_index),
    .pendingCnt_o     (pending_cnt),
    .stqFree_o        (stq_free),
    .stqFreeIndex_o   (stq_free_index),
    .commitOverflow_o (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Behavioural model: integer counters and mod-DEPTH arithmetic.
  int m_commit, m_drain, m_pending, m_free_idx;
  bit m_req, m_ovf, m_free;
  int n_commit, n_drain, n_pending, n_free_idx, cnt, sum;
  bit n_req, n_ovf, n_free, fire;

  always_comb begin
    cnt        = $countones(commit_store);
    fire       = m_req && drain_ack;
    sum        = m_pending + cnt - (fire ? 1 : 0);
    n_ovf      = m_ovf || (sum > DEPTH);
    n_pending  = (sum > DEPTH) ? DEPTH : sum;
    n_commit   = (m_commit + cnt) % DEPTH;
    n_drain    = fire ? (m_drain + 1) % DEPTH : m_drain;
    n_free     = fire;
    n_free_idx = fire ? m_drain : 0;
    if (!m_req)    n_req = (m_pending != 0) && drain_en;
    else if (fire) n_req = (n_pending != 0) && drain_en;
    else           n_req = 1'b1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_commit <= 0; m_drain <= 0; m_pending <= 0; m_free_idx <= 0;
      m_req <= 1'b0; m_ovf <= 1'b0; m_free <= 1'b0;
    end else begin
      m_commit <= n_commit; m_drain <= n_drain; m_pending <= n_pending;
      m_free_idx <= n_free_idx; m_req <= n_req; m_ovf <= n_ovf; m_free <= n_free;
    end
  end

  function automatic logic [63:0] exp_index(input int ptr, input int c);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < c; j++) r[j*LOG +: LOG] = LOG'((ptr + j) % DEPTH);
    return r;
  endfunction

  function automatic logic [63:0] exp_valid(input int c);
    return 64'((1 << c) - 1);
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("count",       64'(st_count),       64'($countones(commit_store)));
      check("valid",       64'(st_valid),       exp_valid($countones(commit_store)));
      check("index",       64'(st_index),       exp_index(m_commit, $countones(commit_store)));
      check("commit_ptr",  64'(commit_ptr),     64'(m_commit));
      check("drain_req",   64'(drain_req),      64'(m_req));
      check("drain_index", 64'(drain_index),    64'(m_drain));
      check("pending",     64'(pending_cnt),    64'(m_pending));
      check("free",        64'(stq_free),       64'(m_free));
      check("free_index",  64'(stq_free_index), 64'(m_free_idx));
      check("overflow",    64'(overflow),       64'(m_ovf));
      if (!m_ovf)
        check("ptr_invariant", 64'((int'(drain_index) + int'(pending_cnt)) % DEPTH), 64'(commit_ptr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;
    int rate[3]     = '{30, 50, 90};
    int ack_rate[3] = '{70, 50, 30};
    rst_n = 1'b0; commit_store = '0; drain_en = 1'b0; drain_ack = 1'b0;
    cmp_en = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;

    // Reset state and packed commit indices from ptr 0.
    commit_store = 4'b1010; #1;
    check("rst_ptr", 64'(commit_ptr), 0);
    check("rst_pending", 64'(pending_cnt), 0);
    check("rst_req", 64'(drain_req), 0);
    check("t2_count", 64'(st_count), 2);
    check("t2_valid", 64'(st_valid), 64'h3);
    check("t2_index", 64'(st_index), 64'd32);
    tick(); commit_store = '0; #1;
    check("t2_ptr", 64'(commit_ptr), 2);
    check("t2_pending", 64'(pending_cnt), 2);

    // Three pending, request held while ack is low, then back-to-back drain.
    commit_store = 4'b0001; tick(); commit_store = '0; #1;
    check("t4_pending", 64'(pending_cnt), 3);
    drain_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_req", 64'(drain_req), 1);
      check("t4_hold_idx", 64'(drain_index), 0);
    end
    drain_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_free", 64'(stq_free), 1);
      check("t4_free_idx", 64'(stq_free_index), 64'(i));
      check("t4_pending_dec", 64'(pending_cnt), 64'(2 - i));
    end
    check("t4_idle", 64'(drain_req), 0);
    drain_ack = 1'b0; tick();
    check("t4_free_off", 64'(stq_free), 0);

    // Commit and ack in the same edge while requesting.
    commit_store = 4'b0001; tick(); commit_store = '0;
    tick();
    check("t5_req", 64'(drain_req), 1);
    check("t5_idx", 64'(drain_index), 3);
    commit_store = 4'b0011; drain_ack = 1'b1; tick();
    commit_store = '0; drain_ack = 1'b0;
    check("t5_pending", 64'(pending_cnt), 2);
    check("t5_stay_req", 64'(drain_req), 1);
    check("t5_idx_adv", 64'(drain_index), 4);
    drain_ack = 1'b1; repeat (3) tick(); drain_ack = 1'b0; drain_en = 1'b0;
    check("t5_drained", 64'(pending_cnt), 0);

    // Pointer wrap on commit and on drain.
    reset_pulse();
    commit_store = 4'b1111; repeat (7) tick();
    commit_store = 4'b0011; tick(); commit_store = '0;
    check("t3_ptr30", 64'(commit_ptr), 30);
    drain_en = 1'b1; drain_ack = 1'b1;
    waited = 0;
    while (pending_cnt != 0 && waited < 100) begin tick(); waited++; end
    check("t3_drain_done", 64'(pending_cnt), 0);
    check("t3_drain_ptr", 64'(drain_index), 30);
    commit_store = 4'b1111; #1;
    check("t3_wrap_index", 64'(st_index), 64'd33790);
    tick(); commit_store = '0;
    check("t3_ptr_wrap", 64'(commit_ptr), 2);
    waited = 0;
    while (!(drain_req && drain_index == 31) && waited < 20) begin tick(); waited++; end
    check("t3_reach_31", 64'(drain_index), 31);
    tick();
    check("t3_idx_wrap", 64'(drain_index), 0);
    check("t3_req_wrap", 64'(drain_req), 1);
    waited = 0;
    while (pending_cnt != 0 && waited < 20) begin tick(); waited++; end
    check("t3_empty", 64'(pending_cnt), 0);
    drain_en = 1'b0; drain_ack = 1'b0;

    // Overflow saturates and sticks; no request while disabled.
    reset_pulse();
    commit_store = 4'b1111; repeat (8) tick();
    check("t6_full_no_ovf", 64'(overflow), 0);
    check("t6_full", 64'(pending_cnt), 32);
    commit_store = 4'b0001; tick(); commit_store = '0;
    check("t6_ovf", 64'(overflow), 1);
    check("t6_sat", 64'(pending_cnt), 32);
    repeat (3) tick();
    check("t6_sticky", 64'(overflow), 1);
    check("t6_no_req", 64'(drain_req), 0);

    // Asynchronous reset in the middle of a request.
    reset_pulse();
    drain_en = 1'b1;
    commit_store = 4'b0001; tick(); commit_store = '0; tick();
    check("t1_req_before", 64'(drain_req), 1);
    @(negedge clk); #2; rst_n = 1'b0; #1;
    check("t1_req_async", 64'(drain_req), 0);
    check("t1_pending_async", 64'(pending_cnt), 0);
    check("t1_ptr_async", 64'(commit_ptr), 0);
    check("t1_ovf_async", 64'(overflow), 0);
    repeat (2) tick();
    rst_n = 1'b1; drain_en = 1'b0;
    repeat (2) tick();
    check("t1_req_after", 64'(drain_req), 0);
    check("t1_pending_after", 64'(pending_cnt), 0);

    // Randomized traffic at three load levels.
    for (int p = 0; p < 3; p++) begin
      reset_pulse();
      for (int i = 0; i < 700; i++) begin
        commit_store = ($urandom_range(99) < rate[p]) ? CW'($urandom) : '0;
        drain_en     = ($urandom_range(99) < 85);
        drain_ack    = ($urandom_range(99) < ack_rate[p]);
        tick();
      end
    end

    commit_store = '0; drain_en = 1'b0; drain_ack = 1'b0;
    tick();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
